// File: rtl/fp_to_int_pipe.sv
// fp_to_int_pipe: two-stage FP32 -> integer converter (fcvt.w/wu/l/lu.s).
//   Stage 1 unpacks the operand and aligns the significand into a 64.2
//   fixed-point field (64 integer bits, guard, sticky).
//   Stage 2 rounds, negates, saturates and produces {NV,DZ,OF,UF,NX}.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    input handshake
//   a_i, sign_i, long_i, rm_i  operand, signed result, 64-bit result, rounding mode
//   tag_i / tag_o              opaque tag carried with the operation
//   out_valid_o / out_ready_i  output handshake
//   int_o, fflags_o            result (32-bit results sign-extended) and flags
module fp_to_int_pipe #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      a_i,
    input  logic             sign_i,
    input  logic             long_i,
    input  logic [2:0]       rm_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      int_o,
    output logic [4:0]       fflags_o,
    output logic [TAG_W-1:0] tag_o
);

    // Round-up decision; unused codes 5-7 fall back to RNE.
    function automatic logic round_up(input logic [2:0] rm, input logic neg,
                                      input logic g, input logic s, input logic lsb);
        case (rm)
            3'd1:    return 1'b0;
            3'd2:    return neg & (g | s);
            3'd3:    return ~neg & (g | s);
            3'd4:    return g;
            default: return g & (s | lsb);
        endcase
    endfunction

    // Rounded magnitude outside the destination range. For unsigned
    // destinations any negative value with a nonzero magnitude is invalid.
    function automatic logic out_of_range(input logic [64:0] mag, input logic neg,
                                          input logic is_signed, input logic is_long);
        logic [64:0] lim;
        if (is_long) lim = is_signed ? 65'h0_7FFF_FFFF_FFFF_FFFF : 65'h0_FFFF_FFFF_FFFF_FFFF;
        else         lim = is_signed ? 65'h0_0000_0000_7FFF_FFFF : 65'h0_0000_0000_FFFF_FFFF;
        if (!neg)           return mag > lim;
        else if (is_signed) return mag > (lim + 65'd1);
        else                return mag != 65'd0;
    endfunction

    // Saturation value, already sign-extended to 64 bits.
    function automatic logic [63:0] sat_value(input logic want_max, input logic is_signed,
                                              input logic is_long);
        if (is_long) begin
            if (is_signed) return want_max ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
            else           return want_max ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
        end else begin
            if (is_signed) return want_max ? 64'h0000_0000_7FFF_FFFF : 64'hFFFF_FFFF_8000_0000;
            else           return want_max ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
        end
    endfunction

    logic vld_p1, vld_p2;
    logic s1_adv;

    assign s1_adv      = !vld_p2 || out_ready_i;
    assign in_ready_o  = !vld_p1 || s1_adv;
    assign out_valid_o = vld_p2;

    // ---- Stage 0 -> 1: unpack and align ----
    logic [7:0]         exp_p0;
    logic [23:0]        sig_p0;
    logic signed [9:0]  e_p0;
    logic [6:0]         sh_p0;
    logic [127:0]       fix_p0;
    logic               nan_p0, inf_p0, ovf_p0;
    logic [63:0]        mag_p0;
    logic               g_p0, s_p0;

    always_comb begin
        exp_p0 = a_i[30:23];
        nan_p0 = (exp_p0 == 8'hFF) && (a_i[22:0] != 23'd0);
        inf_p0 = (exp_p0 == 8'hFF) && (a_i[22:0] == 23'd0);
        sig_p0 = {exp_p0 != 8'd0, a_i[22:0]};
        // Subnormals share the exponent of the smallest normal.
        e_p0   = $signed({2'b00, (exp_p0 == 8'd0) ? 8'd1 : exp_p0}) - 10'sd127;
        ovf_p0 = e_p0 > 10'sd63;
        sh_p0  = '0;
        fix_p0 = '0;
        mag_p0 = '0;
        g_p0   = 1'b0;
        s_p0   = 1'b0;
        if (ovf_p0) begin
            // magnitude irrelevant: result saturates
        end else if (e_p0 < -10'sd1) begin
            // below 0.5: only the sticky bit survives
            s_p0 = |sig_p0;
        end else begin
            // Binary point sits between bits 64 and 63 of fix_p0.
            sh_p0  = 7'(e_p0 + 10'sd41);
            fix_p0 = {104'b0, sig_p0} << sh_p0;
            mag_p0 = fix_p0[127:64];
            g_p0   = fix_p0[63];
            s_p0   = |fix_p0[62:0];
        end
    end

    logic [63:0]      mag_p1;
    logic             g_p1, s_p1, neg_p1, nan_p1, inf_p1, ovf_p1;
    logic             sgn_p1, long_p1;
    logic [2:0]       rm_p1;
    logic [TAG_W-1:0] tag_p1;

    always_ff @(posedge clk) begin
        if (in_ready_o && in_valid_i) begin
            mag_p1  <= mag_p0;
            g_p1    <= g_p0;
            s_p1    <= s_p0;
            neg_p1  <= a_i[31];
            nan_p1  <= nan_p0;
            inf_p1  <= inf_p0;
            ovf_p1  <= ovf_p0;
            sgn_p1  <= sign_i;
            long_p1 <= long_i;
            rm_p1   <= rm_i;
            tag_p1  <= tag_i;
        end
    end

    // ---- Stage 1 -> 2: round, negate, saturate ----
    logic        rup_p2;
    logic [64:0] sum_p2;
    logic [63:0] val_p2, res_p2;
    logic        nv_p2, nx_p2;

    always_comb begin
        rup_p2 = round_up(rm_p1, neg_p1, g_p1, s_p1, mag_p1[0]);
        sum_p2 = {1'b0, mag_p1} + {64'b0, rup_p2};
        val_p2 = neg_p1 ? (~sum_p2[63:0] + 64'd1) : sum_p2[63:0];
        res_p2 = long_p1 ? val_p2 : {{32{val_p2[31]}}, val_p2[31:0]};
        nv_p2  = 1'b0;
        nx_p2  = g_p1 | s_p1;
        if (nan_p1) begin
            res_p2 = sat_value(1'b1, sgn_p1, long_p1);
            nv_p2  = 1'b1;
            nx_p2  = 1'b0;
        end else if (inf_p1 || ovf_p1 || out_of_range(sum_p2, neg_p1, sgn_p1, long_p1)) begin
            res_p2 = sat_value(!neg_p1, sgn_p1, long_p1);
            nv_p2  = 1'b1;
            nx_p2  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            int_o    <= '0;
            fflags_o <= '0;
            tag_o    <= '0;
        end else begin
            if (in_ready_o) vld_p1 <= in_valid_i;
            if (s1_adv) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    int_o    <= res_p2;
                    fflags_o <= {nv_p2, 3'b000, nx_p2};
                    tag_o    <= tag_p1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_to_int_pipe.sv
module tb_fp_to_int_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] a_i;
    logic        sign_i;
    logic        long_i;
    logic [2:0]  rm_i;
    logic [7:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] int_o;
    logic [4:0]  fflags_o;
    logic [7:0]  tag_o;

    fp_to_int_pipe #(.TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .sign_i(sign_i), .long_i(long_i), .rm_i(rm_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .int_o(int_o), .fflags_o(fflags_o), .tag_o(tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] v;
        logic [4:0]  f;
        logic [7:0]  t;
    } exp_t;

    exp_t       q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    logic [7:0] tag_ctr = 8'd0;
    logic       acc;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    function automatic real pow2(input int k);
        real p = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
        else        for (int i = 0; i < -k; i++) p = p / 2.0;
        return p;
    endfunction

    // Reference: exact real value of the float, rounded with floor/ceil,
    // range-checked against the destination's integer bounds.
    function automatic exp_t ref_conv(input logic [31:0] a, input logic sg, input logic lg,
                                      input logic [2:0] rm);
        exp_t        e;
        int          ex;
        real         x, fl, d, r, m, p, hi_ex, lo;
        logic [63:0] mx, mn, b;
        logic        nx;
        ex = int'(a[30:23]);
        mx = lg ? (sg ? 64'h7FFF_FFFF_FFFF_FFFF : '1) : (sg ? 64'h0000_0000_7FFF_FFFF : '1);
        mn = lg ? (sg ? 64'h8000_0000_0000_0000 : '0) : (sg ? 64'hFFFF_FFFF_8000_0000 : '0);
        e.t = 8'd0;
        if (ex == 255 && a[22:0] != 23'd0) begin
            e.v = mx; e.f = 5'h10; return e;
        end
        if (ex == 255) begin
            e.v = a[31] ? mn : mx; e.f = 5'h10; return e;
        end
        if (ex == 0) x = real'(a[22:0]) * pow2(1 - 150);
        else         x = (real'(a[22:0]) + pow2(23)) * pow2(ex - 150);
        if (a[31]) x = -x;
        fl = $floor(x);
        d  = x - fl;
        case (rm)
            3'd1:    r = (x < 0.0) ? $ceil(x) : fl;
            3'd2:    r = fl;
            3'd3:    r = $ceil(x);
            3'd4:    r = (d > 0.5 || (d == 0.5 && x > 0.0)) ? fl + 1.0 : fl;
            default: begin
                if (d > 0.5)      r = fl + 1.0;
                else if (d < 0.5) r = fl;
                else              r = (fl / 2.0 == $floor(fl / 2.0)) ? fl : fl + 1.0;
            end
        endcase
        nx    = (r != x);
        hi_ex = sg ? pow2(lg ? 63 : 31) : pow2(lg ? 64 : 32);
        lo    = sg ? -pow2(lg ? 63 : 31) : 0.0;
        if (r >= hi_ex) begin
            e.v = mx; e.f = 5'h10;
        end else if (r < lo) begin
            e.v = mn; e.f = 5'h10;
        end else begin
            m = (r < 0.0) ? -r : r;
            b = '0;
            p = pow2(63);
            for (int i = 63; i >= 0; i--) begin
                if (m >= p) begin b[i] = 1'b1; m = m - p; end
                p = p / 2.0;
            end
            if (r < 0.0) b = -b;
            if (!lg) b = {{32{b[31]}}, b[31:0]};
            e.v = b;
            e.f = {4'b0000, nx};
        end
        return e;
    endfunction

    // One cycle, entered and left at a negedge. Outputs are checked against
    // the head of the expected queue; accepted inputs are pushed onto it.
    task automatic step(input logic iv, input logic [31:0] a, input logic sg, input logic lg,
                        input logic [2:0] rm, input logic ordy, input logic use_c,
                        input logic [63:0] cv, input logic [4:0] cf, output logic accepted);
        exp_t e;
        in_valid_i  = iv;
        a_i         = a;
        sign_i      = sg;
        long_i      = lg;
        rm_i        = rm;
        tag_i       = tag_ctr;
        out_ready_i = ordy;
        #1;
        if (q.size() == 0) begin
            check("spurious_out", 64'(out_valid_o), 64'd0);
        end else if (out_valid_o) begin
            check("int", int_o, q[0].v);
            check("fflags", 64'(fflags_o), 64'(q[0].f));
            check("tag", 64'(tag_o), 64'(q[0].t));
            if (ordy) void'(q.pop_front());
        end
        accepted = iv && in_ready_o;
        if (accepted) begin
            if (use_c) begin e.v = cv; e.f = cf; end
            else e = ref_conv(a, sg, lg, rm);
            e.t = tag_ctr;
            q.push_back(e);
            tag_ctr++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dop(input logic [31:0] a, input logic sg, input logic lg, input logic [2:0] rm,
                       input logic [63:0] v, input logic [4:0] f);
        logic ok;
        step(1'b1, a, sg, lg, rm, 1'b1, 1'b1, v, f, ok);
    endtask

    task automatic idle(input logic ordy);
        logic ok;
        step(1'b0, 32'd0, 1'b0, 1'b0, 3'd0, ordy, 1'b0, 64'd0, 5'd0, ok);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
        check("drain_queue_empty", 64'(q.size()), 64'd0);
        check("drain_out_idle", 64'(out_valid_o), 64'd0);
    endtask

    function automatic logic [31:0] gen_a();
        logic [31:0] v;
        int          k;
        k = int'($urandom_range(0, 9));
        v = $urandom;
        if (k < 5) begin
            v[30:23] = 8'($urandom_range(118, 192));
        end else if (k < 7) begin
            v[30:23] = 8'($urandom_range(125, 130));
            v[19:0]  = 20'd0;
        end else if (k == 7) begin
            v[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        end
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid_i = 1'b0; a_i = '0; sign_i = 1'b0; long_i = 1'b0;
        rm_i = '0; tag_i = '0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_int", int_o, 64'd0);
        check("rst_fflags", 64'(fflags_o), 64'd0);
        check("rst_tag", 64'(tag_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready_o), 64'd1);

        // Directed conversions with hand-derived results
        dop(32'h3FC00000, 1, 0, 3'd0, 64'h2, 5'h01);
        dop(32'h3FC00000, 1, 0, 3'd1, 64'h1, 5'h01);
        dop(32'h40200000, 1, 1, 3'd0, 64'h2, 5'h01);
        dop(32'h40200000, 1, 1, 3'd4, 64'h3, 5'h01);
        dop(32'h40200000, 1, 1, 3'd3, 64'h3, 5'h01);
        dop(32'h40200000, 1, 1, 3'd2, 64'h2, 5'h01);
        dop(32'hC0200000, 1, 1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFD, 5'h01);
        dop(32'h7FC00000, 1, 0, 3'd0, 64'h0000_0000_7FFF_FFFF, 5'h10);
        dop(32'h4F000000, 1, 0, 3'd0, 64'h0000_0000_7FFF_FFFF, 5'h10);
        dop(32'h4F000000, 0, 0, 3'd0, 64'hFFFF_FFFF_8000_0000, 5'h00);
        dop(32'hBF800000, 0, 1, 3'd0, 64'h0, 5'h10);
        dop(32'hBF000000, 0, 0, 3'd1, 64'h0, 5'h01);
        dop(32'hFF800000, 1, 1, 3'd0, 64'h8000_0000_0000_0000, 5'h10);
        dop(32'h80000000, 0, 0, 3'd0, 64'h0, 5'h00);
        dop(32'h5F800000, 0, 1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'h10);
        dop(32'h5F7FFFFF, 0, 1, 3'd0, 64'hFFFF_FF00_0000_0000, 5'h00);
        dop(32'hCF000000, 1, 0, 3'd0, 64'hFFFF_FFFF_8000_0000, 5'h00);
        dop(32'h00000001, 1, 0, 3'd3, 64'h1, 5'h01);
        dop(32'h3FC00000, 1, 0, 3'd7, 64'h2, 5'h01);
        drain();

        // Backpressure: two entries fill the pipe, the third is refused
        step(1, 32'h3F800000, 1, 0, 3'd0, 0, 0, 64'd0, 5'd0, acc);
        check("bp_accept_1", 64'(acc), 64'd1);
        step(1, 32'h40000000, 1, 0, 3'd0, 0, 0, 64'd0, 5'd0, acc);
        check("bp_accept_2", 64'(acc), 64'd1);
        step(1, 32'h40400000, 1, 0, 3'd0, 0, 0, 64'd0, 5'd0, acc);
        check("bp_refuse_3", 64'(acc), 64'd0);
        idle(1'b0);
        idle(1'b0);
        check("bp_tput_0", 64'(out_valid_o), 64'd1);
        step(1, 32'h40400000, 1, 0, 3'd0, 1, 0, 64'd0, 5'd0, acc);
        check("bp_accept_3", 64'(acc), 64'd1);
        check("bp_tput_1", 64'(out_valid_o), 64'd1);
        idle(1'b1);
        check("bp_tput_2", 64'(out_valid_o), 64'd1);
        idle(1'b1);
        check("bp_empty_after", 64'(out_valid_o), 64'd0);
        check("bp_queue_empty", 64'(q.size()), 64'd0);

        // Reset with both stages occupied
        step(1, 32'h41200000, 1, 0, 3'd0, 0, 0, 64'd0, 5'd0, acc);
        step(1, 32'h41300000, 1, 0, 3'd0, 0, 0, 64'd0, 5'd0, acc);
        check("mid_full_valid", 64'(out_valid_o), 64'd1);
        in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
        check("mid_rst_int", int_o, 64'd0);
        check("mid_rst_tag", 64'(tag_o), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: visible two cycles after the accepting cycle
        step(1, 32'h40A00000, 1, 0, 3'd0, 1, 1, 64'h5, 5'h00, acc);
        check("lat_accept", 64'(acc), 64'd1);
        check("lat_cycle1", 64'(out_valid_o), 64'd0);
        idle(1'b1);
        check("lat_cycle2", 64'(out_valid_o), 64'd1);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), gen_a(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 7), 1'b0, 64'd0, 5'd0, acc);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
